// File: rtl/clk_div_pkg.sv
// Shared constants, state type and divisor helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DIV_MIN   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } div_state_e;

  function automatic logic [31:0] half_of(input logic [31:0] n);
    return n >> 1;
  endfunction

  function automatic logic is_odd(input logic [31:0] n);
    return (n % 32'd2) == 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_negext.sv
// Falling-edge half-cycle extender: stretches the high phase by half a cycle for odd divisors.
module clk_div_negext (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pos_q,
  input  logic odd,
  output logic clk_out
);

  logic neg_q;
  logic neg_d;

  always_comb begin
    neg_d = odd & pos_q;
  end

  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  // Both OR inputs are flop outputs, so the output is glitch-free.
  assign clk_out = pos_q | neg_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even divisors.
// New divisors are staged and applied only at a period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DIV_DEFAULT = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             div_en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_busy,
  output logic             div_err,
  output logic [CNT_W-1:0] div_cur,
  output logic             clk_out,
  output logic             clk_pulse
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             pos_q, pos_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             pulse_q, pulse_d;

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_inc;
  logic             wrap;
  logic             odd;

  always_comb begin
    half      = CNT_W'(half_of(32'(div_cur_q)));
    cnt_inc   = cnt_q + ONE;
    wrap      = (cnt_q == (div_cur_q - ONE));
    odd       = is_odd(32'(div_cur_q));

    state_d   = state_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    div_cur_d = div_cur_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    pulse_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (busy_q) begin
          div_cur_d = pending_q;
          busy_d    = 1'b0;
        end
        if (div_en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          pos_d   = 1'b1;
          pulse_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          // Divisor swap and disable both land only on the period boundary.
          if (busy_q) begin
            div_cur_d = pending_q;
            busy_d    = 1'b0;
          end
          cnt_d = '0;
          if (div_en) begin
            pos_d   = 1'b1;
            pulse_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            pos_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          pos_d = (cnt_inc < half);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (div_load) begin
      if (busy_q || (div_val < DIV_LO)) begin
        err_d = 1'b1;
      end else begin
        pending_d = div_val;
        busy_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pos_q     <= 1'b0;
      div_cur_q <= DIV_RST;
      pending_q <= DIV_RST;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      div_cur_q <= div_cur_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      pulse_q   <= pulse_d;
    end
  end

  clk_div_negext u_negext (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pos_q     (pos_q),
    .odd       (odd),
    .clk_out   (clk_out)
  );

  assign div_busy  = busy_q;
  assign div_err   = err_q;
  assign div_cur   = div_cur_q;
  assign clk_pulse = pulse_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: half-cycle waveform model plus directed scenarios.
module tb_clk_div_prog;

  localparam int CNT_W       = 8;
  localparam int DIV_DEFAULT = 5;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             div_en;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic             div_busy;
  logic             div_err;
  logic [CNT_W-1:0] div_cur;
  logic             clk_out;
  logic             clk_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed whole cycles within the current output period.
  // The output is high for the first N half-cycles of every 2N half-cycle period.
  bit m_run  = 1'b0;
  bit m_busy = 1'b0;
  bit m_err  = 1'b0;
  int m_el   = 0;
  int m_n    = DIV_DEFAULT;
  int m_pend = DIV_DEFAULT;

  always #5 sys_clk = ~sys_clk;

  clk_div_prog #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .div_en    (div_en),
    .div_load  (div_load),
    .div_val   (div_val),
    .div_busy  (div_busy),
    .div_err   (div_err),
    .div_cur   (div_cur),
    .clk_out   (clk_out),
    .clk_pulse (clk_pulse)
  );

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_run  = 1'b0;
      m_busy = 1'b0;
      m_err  = 1'b0;
      m_el   = 0;
      m_n    = DIV_DEFAULT;
      m_pend = DIV_DEFAULT;
    end else begin
      bit was_busy;
      was_busy = m_busy;
      m_err    = 1'b0;
      if (!m_run) begin
        if (was_busy) begin
          m_n    = m_pend;
          m_busy = 1'b0;
        end
        if (div_en) begin
          m_run = 1'b1;
          m_el  = 0;
        end
      end else if (m_el == m_n - 1) begin
        if (was_busy) begin
          m_n    = m_pend;
          m_busy = 1'b0;
        end
        m_el = 0;
        if (!div_en) m_run = 1'b0;
      end else begin
        m_el = m_el + 1;
      end
      if (div_load) begin
        if (was_busy || int'(div_val) < 2) begin
          m_err = 1'b1;
        end else begin
          m_pend = int'(div_val);
          m_busy = 1'b1;
        end
      end
    end
  end

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input int phase);
    int exp_clk;
    exp_clk = (m_run && (2 * m_el + phase < m_n)) ? 1 : 0;
    checkVal(phase ? "model clk_out (neg)" : "model clk_out (pos)", int'(clk_out), exp_clk);
    checkVal("model clk_pulse", int'(clk_pulse), (m_run && m_el == 0) ? 1 : 0);
    checkVal("model div_busy", int'(div_busy), int'(m_busy));
    checkVal("model div_err", int'(div_err), int'(m_err));
    checkVal("model div_cur", int'(div_cur), m_n);
  endtask

  always @(posedge sys_clk) begin
    #1;
    checkOutput(0);
  end

  always @(negedge sys_clk) begin
    #1;
    checkOutput(1);
  end

  task automatic nextCycle();
    @(posedge sys_clk);
    #3;
  endtask

  task automatic applyStimulus(input logic en, input logic load, input int val);
    div_en   = en;
    div_load = load;
    div_val  = CNT_W'(val);
  endtask

  task automatic loadDivisor(input int val);
    applyStimulus(div_en, 1'b1, val);
    nextCycle();
    applyStimulus(div_en, 1'b0, 0);
  endtask

  task automatic waitNotBusy(input string name);
    int g;
    g = 0;
    while (div_busy && g < 600) begin
      nextCycle();
      g++;
    end
    checkVal({name, " busy clear"}, int'(div_busy), 0);
  endtask

  // Counts half-cycle samples of one full clk_out period starting at a rising edge.
  task automatic measurePeriod(input string name, input int exp_high, input int exp_period);
    int hi;
    int lo;
    int guard;
    hi = 0;
    lo = 0;
    guard = 0;
    do begin @(sys_clk); #1; guard++; end while (clk_out !== 1'b0 && guard < 4000);
    do begin @(sys_clk); #1; guard++; end while (clk_out !== 1'b1 && guard < 4000);
    while (clk_out === 1'b1 && guard < 4000) begin hi++; @(sys_clk); #1; guard++; end
    while (clk_out === 1'b0 && guard < 4000) begin lo++; @(sys_clk); #1; guard++; end
    if (guard >= 4000) begin
      checkVal({name, " timeout"}, 0, 1);
    end else begin
      checkVal({name, " high halves"}, hi, exp_high);
      checkVal({name, " period halves"}, hi + lo, exp_period);
    end
  endtask

  initial begin
    int hi;
    sys_rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 0);
    repeat (3) nextCycle();
    sys_rst_n = 1'b1;
    #1;
    checkVal("reset div_cur", int'(div_cur), 5);
    checkVal("reset div_busy", int'(div_busy), 0);
    checkVal("reset clk_out", int'(clk_out), 0);

    // Default divide-by-5.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 0);
    measurePeriod("n5", 5, 10);
    #2;
    checkVal("n5 div_cur", int'(div_cur), 5);
    checkVal("n5 pulse at start", int'(clk_pulse), 1);

    // Mid-period load of 4.
    nextCycle();
    loadDivisor(4);
    checkVal("n4 busy after load", int'(div_busy), 1);
    waitNotBusy("n4");
    measurePeriod("n4", 4, 8);
    #2;

    // Rejected loads: too small, then while busy.
    nextCycle();
    loadDivisor(1);
    checkVal("small load err", int'(div_err), 1);
    checkVal("small load busy", int'(div_busy), 0);
    nextCycle();
    checkVal("err one cycle", int'(div_err), 0);
    loadDivisor(7);
    loadDivisor(3);
    checkVal("busy load err", int'(div_err), 1);
    waitNotBusy("n7");
    checkVal("n7 first value kept", int'(div_cur), 7);
    measurePeriod("n7", 7, 14);
    #2;

    // Disable at cnt=1 with N=7.
    nextCycle();
    applyStimulus(1'b0, 1'b0, 0);
    hi = 0;
    repeat (10) begin @(sys_clk); #1; if (clk_out) hi++; end
    checkVal("disable tail high halves", hi, 4);
    hi = 0;
    repeat (40) begin @(sys_clk); #1; if (clk_out || clk_pulse) hi++; end
    checkVal("idle quiet", hi, 0);
    #2;
    applyStimulus(1'b1, 1'b0, 0);
    @(posedge sys_clk);
    #1;
    checkVal("reenable clk_out", int'(clk_out), 1);
    checkVal("reenable pulse", int'(clk_pulse), 1);
    #2;

    // Width extremes.
    loadDivisor(255);
    waitNotBusy("n255");
    measurePeriod("n255", 255, 510);
    #2;
    loadDivisor(2);
    waitNotBusy("n2");
    measurePeriod("n2", 2, 4);
    #2;

    // Reset while running N=9 with 3 pending.
    loadDivisor(9);
    waitNotBusy("n9");
    checkVal("n9 div_cur", int'(div_cur), 9);
    checkVal("n9 clk_out high", int'(clk_out), 1);
    loadDivisor(3);
    checkVal("n9 pending busy", int'(div_busy), 1);
    sys_rst_n = 1'b0;
    #1;
    checkVal("async reset clk_out", int'(clk_out), 0);
    checkVal("async reset busy", int'(div_busy), 0);
    checkVal("async reset div_cur", int'(div_cur), 5);
    #2;
    nextCycle();
    nextCycle();
    sys_rst_n = 1'b1;
    #1;
    checkVal("post reset div_cur", int'(div_cur), 5);
    checkVal("post reset busy", int'(div_busy), 0);
    measurePeriod("post reset n5", 5, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
